// File: rtl/reg_status_file.sv
// Architectural register file with per-register rename status.
// Commits write values; dispatch records the newest in-flight producer tag.
module reg_status_file #(
   parameter int NREG = 16,
   parameter int W    = 16,
   parameter int TAGW = 4,
   localparam int AW  = $clog2(NREG)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            disp_valid  [0:3],
   input  logic [AW-1:0]   disp_target [0:3],
   input  logic [TAGW-1:0] disp_head,
   input  logic            flush,
   input  logic            wr_en       [0:3],
   input  logic [AW-1:0]   wr_target   [0:3],
   input  logic [W-1:0]    wr_data     [0:3],
   input  logic [TAGW-1:0] wr_writer   [0:3],
   input  logic [AW-1:0]   rd_addr     [0:7],
   output logic [W-1:0]    rd_value    [0:7],
   output logic            rd_busy     [0:7],
   output logic [TAGW-1:0] rd_tag      [0:7]
);

   logic [W-1:0]    value [NREG];
   logic            busy  [NREG];
   logic [TAGW-1:0] tag   [NREG];

   // Later lanes/slots overwrite earlier ones; dispatch overrides commit-clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int r = 0; r < NREG; r++) begin
            value[r] <= '0;
            busy[r]  <= 1'b0;
            tag[r]   <= '0;
         end
      end else begin
         for (int l = 0; l < 4; l++) begin
            if (wr_en[l]) begin
               value[wr_target[l]] <= wr_data[l];
               if (busy[wr_target[l]] && tag[wr_target[l]] == wr_writer[l])
                  busy[wr_target[l]] <= 1'b0;
            end
         end
         if (flush) begin
            for (int r = 0; r < NREG; r++)
               busy[r] <= 1'b0;
         end else begin
            for (int i = 0; i < 4; i++) begin
               if (disp_valid[i]) begin
                  busy[disp_target[i]] <= 1'b1;
                  tag[disp_target[i]]  <= disp_head + TAGW'(i);
               end
            end
         end
      end
   end

   // Priority low to high: stored state, commit bypass, intra-group rename.
   always_comb begin
      for (int p = 0; p < 8; p++) begin
         rd_value[p] = value[rd_addr[p]];
         rd_busy[p]  = busy[rd_addr[p]];
         rd_tag[p]   = tag[rd_addr[p]];
         for (int l = 0; l < 4; l++) begin
            if (wr_en[l] && wr_target[l] == rd_addr[p] &&
                busy[rd_addr[p]] && tag[rd_addr[p]] == wr_writer[l]) begin
               rd_busy[p]  = 1'b0;
               rd_value[p] = wr_data[l];
            end
         end
         if (!flush) begin
            for (int j = 0; j < 3; j++) begin
               if (j < p / 2 && disp_valid[j] && disp_target[j] == rd_addr[p]) begin
                  rd_busy[p]  = 1'b1;
                  rd_tag[p]   = disp_head + TAGW'(j);
                  rd_value[p] = value[rd_addr[p]];
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_reg_status_file.sv
// Scoreboard bench for reg_status_file: stimulus queues expected reads,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_reg_status_file;

  logic        clk = 1'b0;
  logic        rst;
  logic        disp_valid  [0:3];
  logic [3:0]  disp_target [0:3];
  logic [3:0]  disp_head;
  logic        flush;
  logic        wr_en       [0:3];
  logic [3:0]  wr_target   [0:3];
  logic [15:0] wr_data     [0:3];
  logic [3:0]  wr_writer   [0:3];
  logic [3:0]  rd_addr     [0:7];
  logic [15:0] rd_value    [0:7];
  logic        rd_busy     [0:7];
  logic [3:0]  rd_tag      [0:7];

  reg_status_file dut (
    .clk(clk), .rst(rst),
    .disp_valid(disp_valid), .disp_target(disp_target),
    .disp_head(disp_head), .flush(flush),
    .wr_en(wr_en), .wr_target(wr_target),
    .wr_data(wr_data), .wr_writer(wr_writer),
    .rd_addr(rd_addr), .rd_value(rd_value),
    .rd_busy(rd_busy), .rd_tag(rd_tag)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          port;
    logic        busy;
    logic [3:0]  tag;
    logic [15:0] value;
    bit          chk_v;
    string       name;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;

  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      total++;
      if (rd_busy[e.port] !== e.busy ||
          (e.busy && rd_tag[e.port] !== e.tag) ||
          (e.chk_v && rd_value[e.port] !== e.value)) begin
        bad++;
        $display("FAIL %s port%0d: got busy=%b tag=%0d value=%h, want busy=%b tag=%0d value=%h",
                 e.name, e.port, rd_busy[e.port], rd_tag[e.port],
                 rd_value[e.port], e.busy, e.tag, e.value);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flush = 1'b0;
    disp_head = 4'd0;
    for (int i = 0; i < 4; i++) begin
      disp_valid[i] = 1'b0; disp_target[i] = 4'd0;
      wr_en[i] = 1'b0; wr_target[i] = 4'd0;
      wr_data[i] = 16'd0; wr_writer[i] = 4'd0;
    end
    for (int p = 0; p < 8; p++) rd_addr[p] = 4'd0;
  endtask

  task automatic expect_rd(input int port, input logic [3:0] addr,
                           input logic b, input logic [3:0] t,
                           input logic [15:0] v, input bit cv,
                           input string name);
    exp_t e;
    rd_addr[port] = addr;
    e.port = port; e.busy = b; e.tag = t;
    e.value = v; e.chk_v = cv; e.name = name;
    q.push_back(e);
  endtask

  task automatic disp(input int s, input logic [3:0] t);
    disp_valid[s] = 1'b1;
    disp_target[s] = t;
  endtask

  task automatic commit(input int l, input logic [3:0] t,
                        input logic [15:0] d, input logic [3:0] w);
    wr_en[l] = 1'b1; wr_target[l] = t;
    wr_data[l] = d; wr_writer[l] = w;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;

    for (int r = 0; r < 16; r++) begin
      idle();
      for (int p = 0; p < 8; p++)
        expect_rd(p, 4'(r), 1'b0, 4'd0, 16'h0, 1'b1, "reset");
      step();
    end

    idle(); disp_head = 4'd5; disp(0, 4'd3);
    expect_rd(0, 4'd3, 1'b0, 4'd0, 16'h0, 1'b1, "own_dest");
    step();
    idle();
    expect_rd(0, 4'd3, 1'b1, 4'd5, 16'h0, 1'b0, "r3_busy");
    expect_rd(2, 4'd3, 1'b1, 4'd5, 16'h0, 1'b0, "r3_busy_s1");
    step();
    idle(); commit(0, 4'd3, 16'hBEEF, 4'd5);
    expect_rd(0, 4'd3, 1'b0, 4'd0, 16'hBEEF, 1'b1, "bypass");
    step();
    idle();
    expect_rd(0, 4'd3, 1'b0, 4'd0, 16'hBEEF, 1'b1, "commit_state");
    step();

    idle(); disp_head = 4'd5; disp(0, 4'd3); step();
    idle(); disp_head = 4'd9; disp(0, 4'd3); step();
    idle(); commit(0, 4'd3, 16'h1111, 4'd5);
    expect_rd(0, 4'd3, 1'b1, 4'd9, 16'h0, 1'b0, "stale_bypass");
    step();
    idle();
    expect_rd(0, 4'd3, 1'b1, 4'd9, 16'h1111, 1'b1, "stale_state");
    step();
    idle(); commit(2, 4'd3, 16'h2222, 4'd9);
    expect_rd(1, 4'd3, 1'b0, 4'd0, 16'h2222, 1'b1, "newer_bypass");
    step();
    idle();
    expect_rd(0, 4'd3, 1'b0, 4'd0, 16'h2222, 1'b1, "newer_state");
    step();

    idle(); disp_head = 4'd14;
    disp(0, 4'd2); disp(1, 4'd7); disp(2, 4'd2); disp(3, 4'd8);
    expect_rd(0, 4'd2, 1'b0, 4'd0, 16'h0, 1'b1, "grp_s0");
    expect_rd(2, 4'd2, 1'b1, 4'd14, 16'h0, 1'b0, "grp_s1");
    expect_rd(4, 4'd2, 1'b1, 4'd14, 16'h0, 1'b0, "grp_s2");
    expect_rd(6, 4'd2, 1'b1, 4'd0, 16'h0, 1'b0, "grp_s3_wrap");
    expect_rd(7, 4'd7, 1'b1, 4'd15, 16'h0, 1'b0, "grp_s3_r7");
    step();
    idle();
    expect_rd(0, 4'd2, 1'b1, 4'd0, 16'h0, 1'b0, "grp_r2");
    expect_rd(1, 4'd7, 1'b1, 4'd15, 16'h0, 1'b0, "grp_r7");
    expect_rd(2, 4'd8, 1'b1, 4'd1, 16'h0, 1'b0, "grp_r8");
    step();

    idle(); disp_head = 4'd7; disp(0, 4'd4); step();
    idle(); disp_head = 4'd12; disp(0, 4'd4);
    commit(0, 4'd4, 16'hABCD, 4'd7);
    expect_rd(0, 4'd4, 1'b0, 4'd0, 16'hABCD, 1'b1, "dc_bypass");
    expect_rd(2, 4'd4, 1'b1, 4'd12, 16'h0, 1'b0, "dc_rename");
    step();
    idle();
    expect_rd(0, 4'd4, 1'b1, 4'd12, 16'hABCD, 1'b1, "dc_state");
    step();

    idle();
    commit(1, 4'd9, 16'h0001, 4'd0);
    commit(3, 4'd9, 16'h0003, 4'd0);
    step();
    idle();
    expect_rd(0, 4'd9, 1'b0, 4'd0, 16'h0003, 1'b1, "lane_prio");
    step();

    idle(); disp_head = 4'd3; disp(0, 4'd1); disp(1, 4'd2); step();
    idle(); flush = 1'b1; disp(0, 4'd5);
    expect_rd(0, 4'd1, 1'b1, 4'd3, 16'h0, 1'b0, "flush_cur");
    expect_rd(2, 4'd5, 1'b0, 4'd0, 16'h0, 1'b1, "flush_norename");
    step();
    idle();
    expect_rd(0, 4'd1, 1'b0, 4'd0, 16'h0, 1'b1, "flush_r1");
    expect_rd(1, 4'd2, 1'b0, 4'd0, 16'h0, 1'b1, "flush_r2");
    expect_rd(2, 4'd5, 1'b0, 4'd0, 16'h0, 1'b1, "flush_r5");
    expect_rd(3, 4'd8, 1'b0, 4'd0, 16'h0, 1'b1, "flush_r8");
    expect_rd(4, 4'd4, 1'b0, 4'd0, 16'hABCD, 1'b1, "flush_r4");
    step();

    idle(); disp_head = 4'd2; disp(0, 4'd6);
    commit(0, 4'd10, 16'h5555, 4'd0);
    step();
    idle();
    expect_rd(0, 4'd10, 1'b0, 4'd0, 16'h5555, 1'b1, "pre_rst_r10");
    expect_rd(1, 4'd6, 1'b1, 4'd2, 16'h0, 1'b0, "pre_rst_r6");
    step();
    idle(); rst = 1'b1;
    #1;
    expect_rd(0, 4'd10, 1'b0, 4'd0, 16'h0, 1'b1, "rst_r10");
    expect_rd(1, 4'd6, 1'b0, 4'd0, 16'h0, 1'b1, "rst_r6");
    expect_rd(2, 4'd3, 1'b0, 4'd0, 16'h0, 1'b1, "rst_r3");
    #1;
    if (rd_value[0] !== 16'h0) begin
      bad++;
      $display("FAIL async_rst_val: got value=%h, want value=0000",
               rd_value[0]);
    end
    if (rd_busy[1] !== 1'b0 || rd_tag[1] !== 4'd0) begin
      bad++;
      $display("FAIL async_rst_busy: got busy=%b tag=%0d, want busy=0 tag=0",
               rd_busy[1], rd_tag[1]);
    end
    step();
    idle(); disp_head = 4'd1; disp(1, 4'd6);
    commit(0, 4'd10, 16'h7777, 4'd0);
    expect_rd(0, 4'd10, 1'b0, 4'd0, 16'h0, 1'b1, "rst_hold_r10");
    step();
    idle(); rst = 1'b0;
    expect_rd(1, 4'd6, 1'b0, 4'd0, 16'h0, 1'b1, "rst_hold_r6");
    step();
    step();

    if (total == 0) begin
      bad++;
      $display("FAIL scoreboard: got total=0, want total>0");
    end
    if (bad != 0)
      $display("FAIL summary: got bad=%0d, want bad=0", bad);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish, want finish");
    $fatal(1);
  end

endmodule
